wb_drain_buffer: RTL and testbench

// - Dirty-line write-back buffer between the data cache and the AXI bridge (my_axi_interface write channel).
// - Accepts evicted lines from the dcache in one cycle and frees the cache to refill immediately.
// - Drains each line as one INCR burst of LINE_WORDS beats through the cache_* write port, oldest first.
// - Exposes an address-match check so a refill of a line still in the buffer is held until it drains.

---
 rtl/wb_drain_buffer_if.sv | 50 +++++
 rtl/wb_drain_buffer.sv | 193 +++++++++++++++++++
 tb/tb_wb_drain_buffer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_drain_buffer_if.sv
// -----------------------------------------------------------------------------
// wb_drain_buffer_if
// Purpose: bundles the dcache-side push/check signals and the bridge-side
//          write-port signals of the dirty-line write-back buffer.
// Modports:
//   slave  - the buffer itself (receives pushes and bridge acks, drives the bus)
//   master - the environment (dcache + AXI bridge side)
// Handshake:
//   A line transfers on a rising clock edge where push_valid && push_ready.
//   push_ready depends only on registered occupancy, never on push_valid.
//   On the bridge side a beat transfers on an edge where bus_wvalid &&
//   bus_beat_ack; bus_wdata/bus_wlast stay stable until that edge.
// -----------------------------------------------------------------------------
interface wb_drain_buffer_if #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
);
  logic                     push_valid;
  logic                     push_ready;
  logic [ADDR_W-1:0]        push_addr;
  logic [32*LINE_WORDS-1:0] push_data;
  logic [ADDR_W-1:0]        chk_addr;
  logic                     chk_hit;
  logic [31:0]              chk_data;
  logic                     empty;
  logic                     bus_ce;
  logic                     bus_wen;
  logic [ADDR_W-1:0]        bus_waddr;
  logic [31:0]              bus_wdata;
  logic                     bus_wvalid;
  logic                     bus_wlast;
  logic [3:0]               bus_sel;
  logic [7:0]               bus_wlen;
  logic                     bus_beat_ack;
  logic                     bus_bvalid;

  modport slave (
    input  push_valid, push_addr, push_data, chk_addr, bus_beat_ack, bus_bvalid,
    output push_ready, chk_hit, chk_data, empty,
           bus_ce, bus_wen, bus_waddr, bus_wdata, bus_wvalid, bus_wlast,
           bus_sel, bus_wlen
  );

  modport master (
    output push_valid, push_addr, push_data, chk_addr, bus_beat_ack, bus_bvalid,
    input  push_ready, chk_hit, chk_data, empty,
           bus_ce, bus_wen, bus_waddr, bus_wdata, bus_wvalid, bus_wlast,
           bus_sel, bus_wlen
  );
endinterface

// File: rtl/wb_drain_buffer.sv
// -----------------------------------------------------------------------------
// wb_drain_buffer
// Purpose: dirty-line write-back buffer between the data cache and the AXI
//          bridge write port. Evicted lines are accepted in one cycle into a
//          circular FIFO and drained oldest first, each as one INCR burst of
//          LINE_WORDS beats. An entry stays visible to the address check until
//          the bridge reports the write response, so a refill of that line can
//          be held (or forwarded) instead of reading stale memory.
// Optional feature macro: WB_FORWARD_EN
//   defined     - chk_data returns the addressed word of the youngest matching
//                 entry so the dcache can refill from the buffer.
//   not defined - chk_data is tied to 0; the dcache stalls while chk_hit=1.
// Ports:
//   clk         in  system clock
//   resetn      in  asynchronous active-low reset
//   bus         wb_drain_buffer_if.slave (push/check/bridge signals)
//   dbg_state_o out drain FSM state (IDLE=0, REQ=1, DATA=2, RESP=3)
// -----------------------------------------------------------------------------
module wb_drain_buffer #(
  parameter int DEPTH      = 2,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_drain_buffer_if.slave     bus,
  output logic [1:0]           dbg_state_o
);
  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int OFF     = LW_BITS + 2;           // byte offset bits inside a line
  localparam int TAG_W   = ADDR_W - OFF;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LINE_W  = 32 * LINE_WORDS;
  localparam logic [LW_BITS-1:0] LAST_BEAT = LW_BITS'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LW_BITS-1:0] beat_q, beat_d;

  // Line storage holds only the line tag; the offset bits are always zero.
  logic [TAG_W-1:0]   tag_q  [DEPTH];
  logic [LINE_W-1:0]  data_q [DEPTH];

  logic               do_push;
  logic               do_pop;
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   match;
  logic [PTR_W-1:0]   slot_off;
  logic [ADDR_W-1:0]  head_addr;
  logic [LINE_W-1:0]  head_line;

  // Offset bits of the incoming addresses are don't-care by definition.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.push_addr[OFF-1:0], bus.chk_addr[OFF-1:0]};

  // Full is judged on the registered count: a pop in this cycle cannot make
  // room for a push in the same cycle.
  assign bus.push_ready = (count_q != CNT_W'(DEPTH));
  assign do_push        = bus.push_valid && bus.push_ready;
  // Entry leaves the buffer only once the write response has been seen.
  assign do_pop         = (state_q == S_RESP) && bus.bus_bvalid;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_q[wr_ptr_q]  <= bus.push_addr[ADDR_W-1:OFF];
      data_q[wr_ptr_q] <= bus.push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_REQ;
      S_REQ:  state_d = S_DATA;
      S_DATA: begin
        if (bus.bus_beat_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_RESP;
          end else begin
            beat_d = beat_q + LW_BITS'(1);
          end
        end
      end
      S_RESP: begin
        if (bus.bus_bvalid) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
    end
  end

  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Bridge write port, driven from the head entry. Address/data are gated to
  // zero outside the burst so stale storage never appears after reset.
  // ---------------------------------------------------------------------------
  assign head_addr = {tag_q[rd_ptr_q], {OFF{1'b0}}};
  assign head_line = data_q[rd_ptr_q];

  assign bus.bus_ce     = (state_q == S_REQ);
  assign bus.bus_wen    = (state_q == S_REQ);
  assign bus.bus_waddr  = (state_q == S_REQ || state_q == S_DATA) ? head_addr : '0;
  assign bus.bus_wvalid = (state_q == S_DATA);
  assign bus.bus_wdata  = (state_q == S_DATA) ? head_line[{beat_q, 5'b0} +: 32] : 32'h0;
  assign bus.bus_wlast  = (state_q == S_DATA) && (beat_q == LAST_BEAT);
  assign bus.bus_sel    = 4'b1111;
  assign bus.bus_wlen   = 8'(LINE_WORDS - 1);
  assign bus.empty      = (count_q == '0) && (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Address check. A slot is valid when its distance from rd_ptr is below
  // count; the head stays valid through the whole drain until popped.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid    = '0;
    match    = '0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr_q;
      valid[i] = ({1'b0, slot_off} < count_q);
      match[i] = valid[i] && (tag_q[i] == bus.chk_addr[ADDR_W-1:OFF]);
    end
  end

  assign bus.chk_hit = |match;

`ifdef WB_FORWARD_EN
  logic [LINE_W-1:0] fwd_line;
  logic [PTR_W-1:0]  fwd_idx;

  // Walk from oldest to youngest so the youngest matching copy wins.
  always_comb begin
    fwd_line = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if (match[fwd_idx]) fwd_line = data_q[fwd_idx];
    end
  end

  assign bus.chk_data = fwd_line[{bus.chk_addr[OFF-1:2], 5'b0} +: 32];
`else
  assign bus.chk_data = 32'h0;
`endif

endmodule

// File: tb/tb_wb_drain_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_drain_buffer
// Directed bench for wb_drain_buffer (DEPTH=2, LINE_WORDS=8, ADDR_W=32).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Line data convention: word i of a line pushed with base b is b+i.
// -----------------------------------------------------------------------------
module tb_wb_drain_buffer;
  localparam int DEPTH      = 2;
  localparam int LINE_WORDS = 8;
  localparam int ADDR_W     = 32;
  localparam logic [31:0] NO_LINE = 32'hFFFF_FFC0;

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  wb_drain_buffer_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) bif ();

  wb_drain_buffer #(
    .DEPTH(DEPTH), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bif.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input logic [31:0] addr, input logic [31:0] base);
    bif.push_addr = addr;
    for (int i = 0; i < LINE_WORDS; i++) bif.push_data[i*32 +: 32] = base + 32'(i);
  endtask

  task automatic record_line(input logic [31:0] addr, input logic [31:0] base);
    exp_addr_q.push_back({addr[31:5], 5'b0});
    for (int i = 0; i < LINE_WORDS; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_push_ready"}, bif.push_ready, 1);
    check({pfx, "_empty"},      bif.empty, 1);
    check({pfx, "_chk_hit"},    bif.chk_hit, 0);
    check({pfx, "_chk_data"},   bif.chk_data, 0);
    check({pfx, "_ce"},         bif.bus_ce, 0);
    check({pfx, "_wen"},        bif.bus_wen, 0);
    check({pfx, "_wvalid"},     bif.bus_wvalid, 0);
    check({pfx, "_wlast"},      bif.bus_wlast, 0);
    check({pfx, "_waddr"},      bif.bus_waddr, 0);
    check({pfx, "_wdata"},      bif.bus_wdata, 0);
    check({pfx, "_sel"},        bif.bus_sel, 4'hF);
    check({pfx, "_wlen"},       bif.bus_wlen, 8'd7);
    check({pfx, "_state"},      dbg_state, 2'd0);
  endtask

  // ---------------- driver: dcache push ----------------
  task automatic push_line(input logic [31:0] addr, input logic [31:0] base);
    int n;
    bif.push_valid = 1'b1;
    set_line(addr, base);
    n = 0;
    while (!bif.push_ready && n < 200) begin
      tick();
      n++;
    end
    check("push_ready_wait", bif.push_ready, 1);
    tick();
    bif.push_valid = 1'b0;
    record_line(addr, base);
  endtask

  // ---------------- driver: bridge ----------------
  // gap: idle cycles before each beat is acked. abort_beat: stop (without ack)
  // once this beat is presented. push_b: push a new line in the bvalid cycle.
  task automatic drain(input int gap, input int abort_beat, input bit push_b,
                       input logic [31:0] p_addr, input logic [31:0] p_base);
    int n;
    logic [31:0] ea;
    logic [31:0] ew;
    n = 0;
    while (!bif.bus_ce && n < 50) begin
      tick();
      n++;
    end
    check("req_ce", bif.bus_ce, 1);
    if (exp_addr_q.size() == 0) begin
      check("sb_addr_avail", 0, 1);
      return;
    end
    ea = exp_addr_q.pop_front();
    check("req_wen", bif.bus_wen, 1);
    check("req_waddr", bif.bus_waddr, ea);
    check("req_wvalid", bif.bus_wvalid, 0);
    tick();
    check("data_ce_one_cycle", bif.bus_ce, 0);
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (exp_q.size() == 0) begin
        check("sb_word_avail", 0, 1);
        return;
      end
      ew = exp_q.pop_front();
      for (int g = 0; g < gap; g++) begin
        check("hold_wdata", bif.bus_wdata, ew);
        check("hold_wvalid", bif.bus_wvalid, 1);
        tick();
      end
      check("beat_wdata", bif.bus_wdata, ew);
      check("beat_wvalid", bif.bus_wvalid, 1);
      check("beat_wlast", bif.bus_wlast, (b == LINE_WORDS - 1));
      check("beat_waddr", bif.bus_waddr, ea);
      if (b == abort_beat) return;
      bif.bus_beat_ack = 1'b1;
      tick();
      bif.bus_beat_ack = 1'b0;
    end
    check("resp_wvalid", bif.bus_wvalid, 0);
    check("resp_empty", bif.empty, 0);
    check("resp_chk_hit", bif.chk_hit, (bif.chk_addr[31:5] == ea[31:5]));
    tick();
    check("resp_still_held", bif.empty, 0);
    bif.bus_bvalid = 1'b1;
    if (push_b) begin
      bif.push_valid = 1'b1;
      set_line(p_addr, p_base);
      check("push_with_pop_ready", bif.push_ready, 1);
    end
    tick();
    bif.bus_bvalid = 1'b0;
    if (push_b) begin
      bif.push_valid = 1'b0;
      record_line(p_addr, p_base);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp_fwd;
    tests_run        = 0;
    tests_failed     = 0;
    resetn           = 1'b0;
    bif.push_valid   = 1'b0;
    bif.push_addr    = '0;
    bif.push_data    = '0;
    bif.chk_addr     = NO_LINE;
    bif.bus_beat_ack = 1'b0;
    bif.bus_bvalid   = 1'b0;
`ifdef WB_FORWARD_EN
    exp_fwd = 32'hA2;
`else
    exp_fwd = 32'h0;
`endif

    repeat (3) tick();
    check_reset_outputs("rst");
    resetn = 1'b1;
    tick();

    // Line A, immediate acks, address check while pending.
    push_line(32'h1000_0040, 32'hA0);
    bif.chk_addr = 32'h1000_0048;
    #1;
    check("a_empty_after_push", bif.empty, 0);
    check("a_chk_hit", bif.chk_hit, 1);
    check("a_chk_data", bif.chk_data, exp_fwd);
    drain(0, 99, 1'b0, 32'h0, 32'h0);
    check("a_chk_hit_after_b", bif.chk_hit, 0);
    check("a_empty_after_b", bif.empty, 1);
    bif.chk_addr = NO_LINE;

    // Line B with unaligned push address, acks every 3rd cycle.
    push_line(32'h2000_0087, 32'hB0);
    drain(2, 99, 1'b0, 32'h0, 32'h0);

    // Fill both slots while the first drains; third line waits for bvalid.
    push_line(32'h3000_0000, 32'hC0);
    push_line(32'h3000_0020, 32'hD0);
    bif.push_valid = 1'b1;
    set_line(32'h3000_0040, 32'hE0);
    #1;
    check("full_push_ready", bif.push_ready, 0);
    check("full_no_hit", bif.chk_hit, 0);
    drain(1, 99, 1'b0, 32'h0, 32'h0);
    check("full_ready_after_b", bif.push_ready, 1);
    tick();
    bif.push_valid = 1'b0;
    record_line(32'h3000_0040, 32'hE0);
    check("full_again", bif.push_ready, 0);

    // Drain D, then push F in the same cycle E is popped.
    drain(1, 99, 1'b0, 32'h0, 32'h0);
    drain(0, 99, 1'b1, 32'h3000_0060, 32'hF0);
    check("swap_empty", bif.empty, 0);
    check("swap_ready", bif.push_ready, 1);
    bif.chk_addr = 32'h3000_0064;
    #1;
    check("swap_chk_hit", bif.chk_hit, 1);
    bif.chk_addr = NO_LINE;
    drain(0, 99, 1'b0, 32'h0, 32'h0);
    check("swap_empty_end", bif.empty, 1);

    // Reset in the middle of a burst (beat 4 on the bus).
    push_line(32'h4000_0000, 32'h50);
    bif.chk_addr = 32'h4000_0010;
    drain(0, 4, 1'b0, 32'h0, 32'h0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_q.delete();
    exp_addr_q.delete();
    bif.chk_addr = NO_LINE;
    tick();
    resetn = 1'b1;
    tick();
    push_line(32'h5000_0020, 32'h60);
    drain(1, 99, 1'b0, 32'h0, 32'h0);
    check("final_empty", bif.empty, 1);
    check("final_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
